// File: rtl/attex_dma_sequencer.sv
// attex_dma_sequencer: single-channel word DMA between the CDIC (single-address req/ack/rdy/dtc/
// done handshake) and MCD212-decoded memory. While a burst is running it keeps the SCC68070 off
// the bus and asks the MCD212 to let the transfer win over video fetch.
//
// Ports
//   clk30, reset          system clock, synchronous active-high reset
//   start/dir/cfg_addr/cfg_count  one-cycle program strobe and its transfer parameters
//   abort                 stop at the next word boundary
//   busy, done_irq, err   channel status (err is sticky until the next accepted start)
//   cur_addr, remaining   live word address and words left
//   dev_req/dev_done_in   device request / device-initiated termination
//   dev_ack/dev_rdy/dev_dtc/dev_done_out  device handshake outputs
//   mem_cs/mem_we/mem_addr/mem_bus_ack    memory word cycle
//   cpu_idle, hold_cpu    CPU bus arbitration
//   starve_override       tells the MCD212 not to stall the transfer for video fetch
module attex_dma_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic             clk30,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [22:0]      cfg_addr,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             abort,
  output logic             busy,
  output logic             done_irq,
  output logic             err,
  output logic [22:0]      cur_addr,
  output logic [CNT_W-1:0] remaining,
  input  logic             dev_req,
  input  logic             dev_done_in,
  output logic             dev_ack,
  output logic             dev_rdy,
  output logic             dev_dtc,
  output logic             dev_done_out,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [22:0]      mem_addr,
  input  logic             mem_bus_ack,
  input  logic             cpu_idle,
  output logic             hold_cpu,
  output logic             starve_override
);

  localparam int unsigned TmoW = 10;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StArmed, StWaitBus, StXfer, StGap, StDone, StError
  } state_e;

  state_e           state_q, state_d;
  logic [22:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             term_q, term_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             dtc_q, dtc_d;
  logic             done_out_q, done_out_d;
  logic             done_irq_q, done_irq_d;
  logic             term_now;

  assign term_now = abort | dev_done_in;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    err_d      = err_q;
    term_d     = term_q;
    tmo_d      = tmo_q;
    dtc_d      = 1'b0;
    done_out_d = 1'b0;
    done_irq_d = (state_q == StDone) || (state_q == StError);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = cfg_addr;
          rem_d   = cfg_count;
          dir_d   = dir;
          err_d   = 1'b0;
          term_d  = 1'b0;
          state_d = (cfg_count == '0) ? StDone : StArmed;
        end
      end
      StArmed: begin
        if (term_now) begin
          state_d = StDone;
        end else if (dev_req) begin
          state_d = StWaitBus;
        end
      end
      StWaitBus: begin
        if (term_now) begin
          state_d = StDone;
        end else if (cpu_idle) begin
          state_d = StXfer;
          tmo_d   = '0;
        end
      end
      StXfer: begin
        // A terminate during a word only takes effect once that word has finished.
        term_d = term_q | term_now;
        if (mem_bus_ack) begin
          addr_d = addr_q + 23'd1;
          rem_d  = rem_q - CNT_W'(1);
          dtc_d  = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            done_out_d = ~(term_q | term_now);
            state_d    = StDone;
          end else begin
            state_d = StGap;
          end
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StError;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StGap: begin
        if (term_q | term_now) begin
          state_d = StDone;
        end else if (dev_req) begin
          state_d = StXfer;
          tmo_d   = '0;
        end else begin
          state_d = StArmed;
        end
      end
      StDone, StError: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk30) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      term_q     <= 1'b0;
      tmo_q      <= '0;
      dtc_q      <= 1'b0;
      done_out_q <= 1'b0;
      done_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      term_q     <= term_d;
      tmo_q      <= tmo_d;
      dtc_q      <= dtc_d;
      done_out_q <= done_out_d;
      done_irq_q <= done_irq_d;
    end
  end

  // hold_cpu is asserted from the first WAIT_BUS cycle and survives GAP only while the
  // channel continues, so it follows directly from the state.
  assign hold_cpu        = (state_q == StWaitBus) || (state_q == StXfer) || (state_q == StGap);
  assign starve_override = hold_cpu || ((state_q == StArmed) && dev_req);
  assign busy            = (state_q != StIdle);
  assign dev_ack         = (state_q == StXfer);
  assign mem_cs          = (state_q == StXfer);
  assign mem_we          = mem_cs & ~dir_q;
  assign dev_rdy         = (state_q == StXfer) && mem_bus_ack;
  assign mem_addr        = addr_q;
  assign cur_addr        = addr_q;
  assign remaining       = rem_q;
  assign err             = err_q;
  assign dev_dtc         = dtc_q;
  assign dev_done_out    = done_out_q;
  assign done_irq        = done_irq_q;

endmodule
